dadda_mac_pipe: RTL
===================

DADDA_MAC_PIPE -- requirements
Module: dadda_mac_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand width A/B in bits (legal 4..32).
REQ-002 The block SHALL have parameter STAGES, default 2, meaning pipeline depth in register stages including the output register (legal 1..4).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operand set valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: pipeline can accept.
REQ-007 The block SHALL have port a, input, WIDTH bits: unsigned multiplicand.
REQ-008 The block SHALL have port b, input, WIDTH bits: unsigned multiplier.
REQ-009 The block SHALL have port m, input, 2*WIDTH bits: unsigned addend.
REQ-010 The block SHALL have port mode, input, 2 bits: 0 plain, 1 accumulate, 2 load, 3 reserved.
REQ-011 The block SHALL have port out_valid, output, 1 bit: res valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: downstream accepts.
REQ-013 The block SHALL have port res, output, 2*WIDTH+1 bits: result.

Function
REQ-014 An input handshake SHALL occur when in_valid and in_ready are both high on a rising clk edge; an output handshake SHALL occur when out_valid and out_ready are both high.
REQ-015 in_ready SHALL equal (!out_valid || out_ready), so the whole pipeline stalls as a unit and no stage is overwritten while res is unaccepted.
REQ-016 A handshaken operation SHALL appear on res with out_valid high exactly STAGES cycles after its input handshake, when no stall occurs; each stall cycle adds one cycle.
REQ-017 Results SHALL leave in input order; no operation SHALL be dropped or duplicated.
REQ-018 The product SHALL be formed as a Dadda-reduced partial-product tree, with the reduction split across the first STAGES-1 stages; the final stage SHALL contain the carry-propagate adder.
REQ-019 Mode 0 SHALL give res = a*b + m (exact, 2*WIDTH+1 bits, never overflows) and SHALL leave the accumulator unchanged.
REQ-020 Mode 2 (load) SHALL give res = a*b + m and SHALL copy res into the internal accumulator.
REQ-021 Mode 1 (accumulate) SHALL give res = a*b + acc, where acc is the 2*WIDTH+1-bit accumulator, and SHALL copy res into acc.
REQ-022 The accumulator SHALL update on the edge that loads the output register, so back-to-back mode-1 operations chain correctly with no bubble.
REQ-023 Mode 3 SHALL behave as mode 0.
REQ-024 Mode-1 overflow beyond 2*WIDTH+1 bits SHALL follow REQ-029/030.
REQ-025 Stage registers SHALL capture only when in_ready is high; out_valid SHALL drop after an output handshake unless a new result is loaded on the same edge.

Reset
REQ-026 Assertion of rst_n low SHALL asynchronously clear out_valid, all internal stage valid bits, res and acc to 0, discarding in-flight operations.
REQ-027 in_ready SHALL be 1 while and after reset, since out_valid is 0.
REQ-028 Deassertion of rst_n SHALL take effect synchronously to the next clk edge; the first accepted operation SHALL follow REQ-016 latency.

Configuration
REQ-029 With macro DADDA_MAC_SAT_EN defined, a mode-1 sum exceeding 2^(2*WIDTH+1)-1 SHALL clamp res and acc to all-ones.
REQ-030 Without DADDA_MAC_SAT_EN, a mode-1 sum SHALL wrap modulo 2^(2*WIDTH+1); modes 0/2 SHALL be unaffected in both builds.

Verification
(All scenarios use WIDTH=8, STAGES=2.)
REQ-031 Max operands: a=255, b=255, m=65535, mode 0, out_ready=1 -> res=130560, out_valid exactly 2 cycles after the handshake.
REQ-032 Chaining: load 3*4+5, then mode 1 with 2*2 on the next cycle -> res=17 then res=21, with no bubble.
REQ-033 Overflow: load 255*255+65535 (130560), then mode 1 with 255*255 -> res=64513 without the macro, 131071 with DADDA_MAC_SAT_EN.
REQ-034 Backpressure: 4 back-to-back ops with out_ready held low 3 cycles -> in_ready low during the stall, all 4 results delivered in order, none lost.
REQ-035 Reset mid-flight: rst_n pulsed low with 2 ops in flight -> out_valid=0, res=0, acc=0 immediately; a subsequent mode-1 op 6*7 -> res=42.

Source files
------------

// File: rtl/dadda_mac_pipe.sv
// Pipelined unsigned multiply-add/accumulate: a*b+m (or a*b+acc) via a Dadda tree.
// Optional macro DADDA_MAC_SAT_EN clamps accumulate overflow to all-ones instead of wrapping.
module dadda_mac_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2*WIDTH-1:0]   m,
  input  logic [1:0]           mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH:0]     res
);

  localparam int NC = 2*WIDTH + 1;
  localparam int H  = WIDTH + 1;
  localparam int P  = (STAGES > 1) ? STAGES - 1 : 1;

  typedef logic [NC-1:0][H-1:0] mat_t;

  function automatic int dadda_d(input int i);
    int d;
    d = 2;
    for (int k = 0; k < i; k++) d = (d * 3) / 2;
    return d;
  endfunction

  function automatic int num_steps(input int hmax);
    int n;
    n = 0;
    for (int k = 0; k < 16; k++) if (dadda_d(k) < hmax) n = k + 1;
    return n;
  endfunction

  localparam int L = num_steps(H);

  function automatic int init_h(input int c);
    int cnt;
    cnt = 0;
    for (int i = 0; i < WIDTH; i++) if (c - i >= 0 && c - i < WIDTH) cnt++;
    if (c < 2*WIDTH) cnt++;
    return cnt;
  endfunction

  // Column layout: partial products first, addend bit on top.
  function automatic mat_t build_pp(input logic [WIDTH-1:0] fa, input logic [WIDTH-1:0] fb,
                                    input logic [2*WIDTH-1:0] fm);
    mat_t mo;
    int   r;
    mo = '0;
    for (int c = 0; c < NC; c++) begin
      r = 0;
      for (int i = 0; i < WIDTH; i++) begin
        if (c - i >= 0 && c - i < WIDTH) begin
          mo[c][r] = fa[c-i] & fb[i];
          r++;
        end
      end
      if (c < 2*WIDTH) mo[c][r] = fm[c];
    end
    return mo;
  endfunction

  // Runs the full Dadda height schedule but only commits the steps owned by stage stg,
  // so every stage shares one description and heights stay parameter-derived.
  function automatic mat_t reduce(input mat_t mi, input int stg);
    mat_t cur, nxt;
    int   h [NC];
    int   pos [NC+1];
    int   d, ex, nfa, nha, idx;
    logic x, y, z;
    cur = mi;
    for (int c = 0; c < NC; c++) h[c] = init_h(c);
    for (int s = 0; s < L; s++) begin
      d   = dadda_d(L - 1 - s);
      nxt = '0;
      for (int c = 0; c <= NC; c++) pos[c] = 0;
      for (int c = 0; c < NC; c++) begin
        ex  = h[c] + pos[c] - d;
        nfa = 0;
        nha = 0;
        if (ex > 0) begin
          nfa = ex / 2;
          if (3 * nfa > h[c]) nfa = h[c] / 3;
          if ((ex - 2 * nfa > 0) && (h[c] - 3 * nfa >= 2)) nha = 1;
        end
        idx = 0;
        for (int k = 0; k < H; k++) begin
          if (k < nfa) begin
            x = cur[c][idx]; y = cur[c][idx+1]; z = cur[c][idx+2];
            if (pos[c] < H) nxt[c][pos[c]] = x ^ y ^ z;
            pos[c]++;
            if (c + 1 < NC && pos[c+1] < H) nxt[c+1][pos[c+1]] = (x & y) | (x & z) | (y & z);
            pos[c+1]++;
            idx += 3;
          end
        end
        if (nha == 1) begin
          x = cur[c][idx]; y = cur[c][idx+1];
          if (pos[c] < H) nxt[c][pos[c]] = x ^ y;
          pos[c]++;
          if (c + 1 < NC && pos[c+1] < H) nxt[c+1][pos[c+1]] = x & y;
          pos[c+1]++;
          idx += 2;
        end
        for (int k = 0; k < H; k++) begin
          if (k >= idx && k < h[c]) begin
            if (pos[c] < H) nxt[c][pos[c]] = cur[c][k];
            pos[c]++;
          end
        end
      end
      if ((s * P) / L == stg) cur = nxt;
      for (int c = 0; c < NC; c++) h[c] = pos[c];
    end
    return cur;
  endfunction

  function automatic logic [NC-1:0] sum_rows(input mat_t mi);
    logic [NC-1:0] acc, row;
    acc = '0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < NC; c++) row[c] = mi[c][r];
      acc = acc + row;
    end
    return acc;
  endfunction

  logic [2*WIDTH-1:0] w_m_eff;
  mat_t               w_mat0;
  mat_t               w_red [P];
  mat_t               r_mat [P];
  logic [P-1:0]       r_vld;
  logic [1:0]         r_mode [P];
  mat_t               w_fin_mat;
  logic               w_fin_vld;
  logic [1:0]         w_fin_mode;
  logic [NC-1:0]      w_sum;
  logic [NC:0]        w_ext;
  logic [NC-1:0]      w_res;
  logic [NC-1:0]      r_acc;

  assign in_ready = !out_valid || out_ready;

  // Accumulate mode adds acc in the final stage, so the tree only sees m in other modes.
  always_comb begin
    w_m_eff = '0;
    if (mode == 2'd1) w_m_eff = '0;
    else              w_m_eff = m;
    w_mat0   = build_pp(a, b, w_m_eff);
    w_red[0] = reduce(w_mat0, 0);
    for (int k = 1; k < P; k++) w_red[k] = reduce(r_mat[k-1], k);
  end

  generate
    if (STAGES > 1) begin : g_piped
      assign w_fin_mat  = r_mat[STAGES-2];
      assign w_fin_vld  = r_vld[STAGES-2];
      assign w_fin_mode = r_mode[STAGES-2];
    end else begin : g_flat
      assign w_fin_mat  = w_red[0];
      assign w_fin_vld  = in_valid;
      assign w_fin_mode = mode;
    end
  endgenerate

  // Final stage: carry-propagate add of the reduced rows, plus acc for accumulate.
  always_comb begin
    w_sum = sum_rows(w_fin_mat);
    w_ext = {1'b0, w_sum} + {1'b0, r_acc};
    if (w_fin_mode == 2'd1) begin
`ifdef DADDA_MAC_SAT_EN
      if (w_ext[NC]) w_res = {NC{1'b1}};
      else           w_res = w_ext[NC-1:0];
`else
      w_res = w_ext[NC-1:0];
`endif
    end else begin
      w_res = w_sum;
    end
  end

  // Tree stage registers advance together whenever the pipeline is not stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < P; k++) begin
        r_vld[k]  <= 1'b0;
        r_mat[k]  <= '0;
        r_mode[k] <= 2'b00;
      end
    end else if (in_ready) begin
      r_vld[0]  <= in_valid;
      r_mat[0]  <= w_red[0];
      r_mode[0] <= mode;
      for (int k = 1; k < P; k++) begin
        r_vld[k]  <= r_vld[k-1];
        r_mat[k]  <= w_red[k];
        r_mode[k] <= r_mode[k-1];
      end
    end
  end

  // Output register and accumulator load on the same edge so accumulate ops chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      res       <= '0;
      r_acc     <= '0;
    end else if (in_ready) begin
      out_valid <= w_fin_vld;
      if (w_fin_vld) begin
        res <= w_res;
        if (w_fin_mode == 2'd1 || w_fin_mode == 2'd2) r_acc <= w_res;
      end
    end
  end

endmodule
